led_hex_decoder: RTL
====================

# led_hex_decoder

Receive-side counterpart of the 4-digit multiplexed 7-segment hex display driver. It samples active-low cathode and anode lines, recovers the 16-bit hexadecimal value being shown, and publishes it atomically once per complete scan frame. It serves as an on-chip loopback monitor for the display path, and as a decoder for an external board's multiplexed display when the emulator is snooping another device.

## Interface
- STABLE, default 1: consecutive identical samples (same anode, same segments) needed to accept a digit; legal range 1..15.
- TIMEOUT_W, default 16: width of the stale counter; `stale` asserts after 2^TIMEOUT_W − 1 cycles without a frame.

Ports:
- sclk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- led_c  in  8  cathodes, active-low; [6:0] = segments g..a, [7] = decimal point.
- led_a  in  4  anodes, active-low; 1110 = digit 0 (number[15:12]), 1101 = digit 1, 1011 = digit 2, 0111 = digit 3 (number[3:0]).
- number  out  16  last complete decoded value.
- frame  out  1  one-cycle pulse when `number` updates.
- err  out  1  one-cycle pulse on an illegal anode or unknown glyph.
- stale  out  1  high when no frame has completed within the timeout.
- dp  out  4  decimal-point state per digit, published with `number`.

## Operation
- Reset values: number = 0, frame = 0, err = 0, stale = 1, dp = 0. All internal state clears, including the sync flops, run counter, shadow and got[3:0].
- Input path: led_c and led_a each pass through a 2-flop synchronizer (s1, s2).
- Run counter:
  - Counts consecutive cycles in which s2 equals the previous s2, saturating at 15.
  - A change in s2 resets it to 1.
  - Qualification happens exactly when the run length reaches STABLE, so each run qualifies at most once.
- Anode decode of a qualified sample:
  - 1111 (blank): ignored, not an error.
  - One-hot-low: selects a digit index.
  - Anything else: error.
- Segment decode, on led_c[6:0] only:
  - Glyph table: 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110.
  - Any other pattern is an error.
- Accepted digit: nibble is written into shadow[digit] and got[digit] is set. Repeats overwrite the nibble; the latest wins.
- Frame completion:
  - Triggered when digit 3 is accepted and got[2:0] = 111.
  - Same edge: number ← shadow with the new digit-3 nibble merged, frame = 1, got cleared, stale counter cleared.
  - Digits 0–2 may arrive in any order; only digit 3 triggers completion.
- Error: err pulses for one cycle and got clears. The shadow nibble is not written, and number is unchanged.
- Stale counter: increments every cycle without a frame and saturates at all-ones. stale = (counter == all-ones). A frame clears both counter and stale on the same edge.

## Timing
- Input edge k: s1 captures. Edge k+1: s2 captures. Edge k+2: decode/accept registers update.
- With STABLE = 1, inputs settled before edge k produce frame/number/err changes visible after edge k+2.
- Each additional STABLE count adds one cycle of required hold and of latency.
- frame and err are registered single-cycle pulses. They are never asserted together, because each qualified sample is either legal or illegal.
- Back-to-back frames are allowed. The driver's 4-cycle scan with STABLE = 1 gives one frame every 4 cycles.
- Asynchronous reset mid-frame: partial got/shadow are discarded, and outputs return to reset values immediately.

## Configuration
- LED_HEX_DECODER_DP_EN defined: led_c[7] is captured per digit alongside the nibble (1 = point off, stored inverted as dp = 1 when lit) and published to dp[3:0] at frame completion.
- Not defined: led_c[7] is ignored and not synchronized, and dp is tied to 4'b0000.

## Test plan
- Glyphs for 1,2,3,4 on anodes 1110, 1101, 1011, 0111, one cycle each, STABLE = 1 → frame pulses once, number = 16'h1234, stale = 0, 2 edges after digit 3's capture edge.
- Digits 0, 2, 3 only (digit 1 never shown) → no frame; number keeps its previous value; got[3] not set.
- Anode 1101 with segments 1111111 → err pulses 1 cycle; the next digit 3 does not complete a frame until digits 0–2 are resent.
- Anode 1100 with a valid glyph → err pulses; blank anode 1111 → no err, no change.
- STABLE = 3: each digit held 2 cycles → no frame; held 3 cycles → frame with number = 16'hABCD.
- TIMEOUT_W = 4, no frames for 15 cycles → stale = 1. With LED_HEX_DECODER_DP_EN and the digit 2 point lit → dp = 4'b0100. Reset mid-frame → all outputs return to reset values.

Source files
------------

// File: rtl/led_hex_decoder.sv
`default_nettype none
// ============================================================================
// Module   : led_hex_decoder
// Brief    : Recovers the hex value shown on a multiplexed, active-low 4-digit
//            7-segment scan and publishes it once per complete frame.
//            Optional decimal-point capture: define LED_HEX_DECODER_DP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module led_hex_decoder #(
    parameter int STABLE    = 1,
    parameter int TIMEOUT_W = 16
) (
    input  logic        sclk,
    input  logic        reset,
    input  logic [7:0]  led_c,
    input  logic [3:0]  led_a,
    output logic [15:0] number,
    output logic        frame,
    output logic        err,
    output logic        stale,
    output logic [3:0]  dp
);

`ifdef LED_HEX_DECODER_DP_EN
    localparam int c_seg_w = 8;
`else
    localparam int c_seg_w = 7;
`endif
    localparam logic [3:0] c_stable = 4'(STABLE);

    logic [c_seg_w-1:0]   r_c_s1, r_c_s2, r_c_prev;
    logic [3:0]           r_a_s1, r_a_s2, r_a_prev;
    logic [3:0]           r_run;
    logic [2:0]           r_got;
    logic [3:0]           r_sh0, r_sh1, r_sh2;
    logic [15:0]          r_number;
    logic                 r_frame, r_err;
    logic [TIMEOUT_W-1:0] r_stale_cnt;

    logic       w_same, w_qual, w_blank, w_a_ok, w_glyph_ok;
    logic       w_acc, w_err, w_done;
    logic [3:0] w_run_nxt, w_nib;
    logic [1:0] w_dig;

    always_comb begin
        w_same = (r_c_s2 == r_c_prev) && (r_a_s2 == r_a_prev);
        if (!w_same)
            w_run_nxt = 4'd1;
        else if (r_run == 4'd15)
            w_run_nxt = 4'd15;
        else
            w_run_nxt = r_run + 4'd1;
    end

    // A saturated run that already sits at STABLE must not re-qualify.
    assign w_qual = (w_run_nxt == c_stable) && !(w_same && (r_run == c_stable));

    always_comb begin
        w_blank = 1'b0;
        w_a_ok  = 1'b1;
        w_dig   = 2'd0;
        case (r_a_s2)
            4'b1111: w_blank = 1'b1;
            4'b1110: w_dig   = 2'd0;
            4'b1101: w_dig   = 2'd1;
            4'b1011: w_dig   = 2'd2;
            4'b0111: w_dig   = 2'd3;
            default: w_a_ok  = 1'b0;
        endcase
    end

    always_comb begin
        w_glyph_ok = 1'b1;
        w_nib      = 4'h0;
        case (r_c_s2[6:0])
            7'b1000000: w_nib = 4'h0;
            7'b1111001: w_nib = 4'h1;
            7'b0100100: w_nib = 4'h2;
            7'b0110000: w_nib = 4'h3;
            7'b0011001: w_nib = 4'h4;
            7'b0010010: w_nib = 4'h5;
            7'b0000010: w_nib = 4'h6;
            7'b1111000: w_nib = 4'h7;
            7'b0000000: w_nib = 4'h8;
            7'b0010000: w_nib = 4'h9;
            7'b0001000: w_nib = 4'hA;
            7'b0000011: w_nib = 4'hB;
            7'b1000110: w_nib = 4'hC;
            7'b0100001: w_nib = 4'hD;
            7'b0000110: w_nib = 4'hE;
            7'b0001110: w_nib = 4'hF;
            default:    w_glyph_ok = 1'b0;
        endcase
    end

    assign w_err  = w_qual && !w_blank && !(w_a_ok && w_glyph_ok);
    assign w_acc  = w_qual && !w_blank && w_a_ok && w_glyph_ok;
    assign w_done = w_acc && (w_dig == 2'd3) && (&r_got);

    // Sync flops clear to all-ones: the idle (blanked) level of the active-low
    // lines, so coming out of reset never qualifies a bogus all-zero anode.
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            r_c_s1      <= '1;
            r_c_s2      <= '1;
            r_c_prev    <= '1;
            r_a_s1      <= 4'hF;
            r_a_s2      <= 4'hF;
            r_a_prev    <= 4'hF;
            r_run       <= 4'd0;
            r_got       <= 3'b000;
            r_sh0       <= 4'h0;
            r_sh1       <= 4'h0;
            r_sh2       <= 4'h0;
            r_number    <= 16'h0000;
            r_frame     <= 1'b0;
            r_err       <= 1'b0;
            r_stale_cnt <= '1;
        end else begin
            r_c_s1   <= led_c[c_seg_w-1:0];
            r_c_s2   <= r_c_s1;
            r_c_prev <= r_c_s2;
            r_a_s1   <= led_a;
            r_a_s2   <= r_a_s1;
            r_a_prev <= r_a_s2;
            r_run    <= w_run_nxt;
            r_frame  <= w_done;
            r_err    <= w_err;

            if (w_err || w_done) begin
                r_got <= 3'b000;
            end else if (w_acc) begin
                case (w_dig)
                    2'd0:    begin r_got[0] <= 1'b1; r_sh0 <= w_nib; end
                    2'd1:    begin r_got[1] <= 1'b1; r_sh1 <= w_nib; end
                    2'd2:    begin r_got[2] <= 1'b1; r_sh2 <= w_nib; end
                    default: ;
                endcase
            end

            if (w_done)
                r_number <= {r_sh0, r_sh1, r_sh2, w_nib};

            if (w_done)
                r_stale_cnt <= '0;
            else if (!(&r_stale_cnt))
                r_stale_cnt <= r_stale_cnt + 1'b1;
        end
    end

    assign number = r_number;
    assign frame  = r_frame;
    assign err    = r_err;
    assign stale  = &r_stale_cnt;

`ifdef LED_HEX_DECODER_DP_EN
    logic [2:0] r_dp_sh;
    logic [3:0] r_dp;
    logic       w_pt;

    assign w_pt = ~r_c_s2[7];

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            r_dp_sh <= 3'b000;
            r_dp    <= 4'b0000;
        end else begin
            if (w_acc) begin
                case (w_dig)
                    2'd0:    r_dp_sh[0] <= w_pt;
                    2'd1:    r_dp_sh[1] <= w_pt;
                    2'd2:    r_dp_sh[2] <= w_pt;
                    default: ;
                endcase
            end
            if (w_done)
                r_dp <= {w_pt, r_dp_sh};
        end
    end

    assign dp = r_dp;
`else
    logic w_unused_dp;
    assign w_unused_dp = led_c[7];
    assign dp = 4'b0000;
`endif

endmodule
`default_nettype wire
